// File: rtl/pad_bus_interface_if.sv
// Pad-side control/data and memory request/acknowledge signals of pad_bus_interface.
// The slave modport is the bus interface block; master is the controller/memory side.
interface pad_bus_interface_if;
   logic        pad_write_address;
   logic        pad_read;
   logic        pad_write;
   logic [1:0]  pad_data_size;
   logic [31:0] address_in;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        read_valid;
   logic        stall;
   logic        misaligned;
   logic        bus_timeout;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output pad_write_address, pad_read, pad_write, pad_data_size, address_in, write_data,
             mem_rdata, mem_ack,
      input  read_data, read_valid, stall, misaligned, bus_timeout, mem_req, mem_we, mem_addr,
             mem_byte_enable, mem_wdata
   );

   modport slave (
      input  pad_write_address, pad_read, pad_write, pad_data_size, address_in, write_data,
             mem_rdata, mem_ack,
      output read_data, read_valid, stall, misaligned, bus_timeout, mem_req, mem_we, mem_addr,
             mem_byte_enable, mem_wdata
   );
endinterface

// File: rtl/pad_bus_interface.sv
// Turns pad read/write requests into a single-outstanding req/ack memory transaction with
// lane alignment, byte enables, alignment checking and an optional bus timeout.
module pad_bus_interface #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic                clock,
   input logic                reset,
   pad_bus_interface_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   localparam bit          TimeoutEn   = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] cnt_q, cnt_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  size_q, size_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] read_data_q, read_data_d;
   logic        read_valid_q, read_valid_d;
   logic        misaligned_q, misaligned_d;
   logic        bus_timeout_q, bus_timeout_d;

   logic [31:0] ea;
   logic        ea_misaligned;
   logic [3:0]  ea_be;
   logic [31:0] ea_wdata;
   logic [31:0] rdata_shifted;
   logic [31:0] rdata_aligned;

   always_comb begin
      ea = bus.pad_write_address ? bus.address_in : addr_q;

      ea_misaligned = 1'b0;
      ea_be         = 4'b1111;
      ea_wdata      = bus.write_data;
      unique case (bus.pad_data_size)
         2'b00: begin
            ea_be    = 4'b0001 << ea[1:0];
            ea_wdata = {4{bus.write_data[7:0]}};
         end
         2'b01: begin
            ea_misaligned = ea[0];
            ea_be         = 4'b0011 << ea[1:0];
            ea_wdata      = {2{bus.write_data[15:0]}};
         end
         default: ea_misaligned = |ea[1:0];
      endcase

      rdata_shifted = bus.mem_rdata >> {lane_q, 3'b000};
      unique case (size_q)
         2'b00:   rdata_aligned = rdata_shifted & 32'h0000_00ff;
         2'b01:   rdata_aligned = rdata_shifted & 32'h0000_ffff;
         default: rdata_aligned = rdata_shifted;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      addr_d        = bus.pad_write_address ? bus.address_in : addr_q;
      cnt_d         = cnt_q;
      lane_d        = lane_q;
      size_d        = size_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_be_d      = mem_be_q;
      mem_wdata_d   = mem_wdata_q;
      read_data_d   = read_data_q;
      read_valid_d  = 1'b0;
      misaligned_d  = 1'b0;
      bus_timeout_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.pad_write || bus.pad_read) begin
               if (ea_misaligned) begin
                  state_d      = StDone;
                  misaligned_d = 1'b1;
                  read_data_d  = '0;
               end else begin
                  // Write wins when both requests are raised together.
                  state_d     = bus.pad_write ? StWrite : StRead;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.pad_write;
                  mem_addr_d  = {ea[31:2], 2'b00};
                  mem_be_d    = ea_be;
                  mem_wdata_d = ea_wdata;
                  lane_d      = ea[1:0];
                  size_d      = bus.pad_data_size;
                  cnt_d       = '0;
               end
            end
         end
         StRead, StWrite: begin
            if (bus.mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = StDone;
               if (state_q == StRead) begin
                  read_valid_d = 1'b1;
                  read_data_d  = rdata_aligned;
               end
            end else if (TimeoutEn && (cnt_q == TimeoutLast)) begin
               mem_req_d     = 1'b0;
               state_d       = StDone;
               bus_timeout_d = 1'b1;
               read_data_d   = '0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         cnt_q         <= '0;
         lane_q        <= '0;
         size_q        <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_be_q      <= '0;
         mem_wdata_q   <= '0;
         read_data_q   <= '0;
         read_valid_q  <= 1'b0;
         misaligned_q  <= 1'b0;
         bus_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         cnt_q         <= cnt_d;
         lane_q        <= lane_d;
         size_q        <= size_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_be_q      <= mem_be_d;
         mem_wdata_q   <= mem_wdata_d;
         read_data_q   <= read_data_d;
         read_valid_q  <= read_valid_d;
         misaligned_q  <= misaligned_d;
         bus_timeout_q <= bus_timeout_d;
      end
   end

   always_comb begin
      bus.stall = ((state_q == StIdle) && (bus.pad_read || bus.pad_write)) ||
                  (state_q == StRead) || (state_q == StWrite);
      bus.read_data       = read_data_q;
      bus.read_valid      = read_valid_q;
      bus.misaligned      = misaligned_q;
      bus.bus_timeout     = bus_timeout_q;
      bus.mem_req         = mem_req_q;
      bus.mem_we          = mem_we_q;
      bus.mem_addr        = mem_addr_q;
      bus.mem_byte_enable = mem_be_q;
      bus.mem_wdata       = mem_wdata_q;
   end

endmodule
